// File: rtl/dmem_map_pkg.sv
// Address map, status-word layout and address decode shared by the data-memory responder.
package dmem_map_pkg;

    localparam logic [31:0] ADDR_CYCLE   = 32'h0000_F000;
    localparam logic [31:0] ADDR_LED     = 32'h0000_F001;
    localparam logic [31:0] ADDR_TX_PUSH = 32'h0000_F002;
    localparam logic [31:0] ADDR_TX_STAT = 32'h0000_F003;

    localparam int STAT_OVF_BIT   = 31;
    localparam int STAT_FULL_BIT  = 9;
    localparam int STAT_EMPTY_BIT = 8;
    localparam int STAT_COUNT_W   = 8;

    typedef enum logic [2:0] {
        REGION_RAM,
        REGION_CYCLE,
        REGION_LED,
        REGION_TX_PUSH,
        REGION_TX_STAT,
        REGION_NONE
    } region_e;

    // RAM takes priority so a large RAM_WORDS never aliases onto a register.
    function automatic region_e decode_addr(input logic [31:0] addr,
                                            input logic [31:0] ram_words);
        region_e region;
        region = REGION_NONE;
        if (addr < ram_words) begin
            region = REGION_RAM;
        end else begin
            case (addr)
                ADDR_CYCLE:   region = REGION_CYCLE;
                ADDR_LED:     region = REGION_LED;
                ADDR_TX_PUSH: region = REGION_TX_PUSH;
                ADDR_TX_STAT: region = REGION_TX_STAT;
                default:      region = REGION_NONE;
            endcase
        end
        return region;
    endfunction

endpackage

// File: rtl/dmem_responder_tx_fifo.sv
// Byte FIFO feeding the character transmitter; registered count drives valid so
// a push into an empty FIFO becomes visible one edge later.
module tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [7:0]               i_push_data,
    input  logic                     i_pop,
    output logic [7:0]               o_head,
    output logic                     o_valid,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_full;
    logic          w_empty;
    logic          w_pop_acc;
    logic          w_push_acc;
    logic [CW-1:0] w_count_next;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // A pop frees the slot the push is about to use, so full+pop still accepts.
    assign w_pop_acc  = i_pop && !w_empty;
    assign w_push_acc = i_push && (!w_full || w_pop_acc);

    always_comb begin
        w_count_next = r_count;
        case ({w_push_acc, w_pop_acc})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head     = r_mem[r_rd_ptr];
    assign o_valid    = !w_empty;
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_count    = r_count;
    assign o_overflow = i_push && w_full && !w_pop_acc;

endmodule

// File: rtl/dmem_responder.sv
// Processor data-memory responder: word RAM, free-running cycle counter, LED
// register and a character TX FIFO, all behind one registered read port.
module dmem_responder
    import dmem_map_pkg::*;
#(
    parameter int RAM_WORDS  = 4096,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [15:0] leds,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]     r_ram [RAM_WORDS];
    logic [31:0]     r_ram_q;
    logic [31:0]     r_reg_q;
    logic            r_rd_is_ram;
    logic [31:0]     r_cycle;
    logic [15:0]     r_leds;
    logic            r_ovf;

    region_e         w_region;
    logic [RAM_AW-1:0] w_ram_idx;
    logic            w_wr_ram;
    logic            w_wr_cycle;
    logic            w_wr_led;
    logic            w_wr_push;
    logic            w_wr_stat;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic            w_fifo_ovf;
    logic [CW-1:0]   w_fifo_count;
    logic [31:0]     w_status;
    logic [31:0]     w_reg_rdata;
    logic            w_ovf_next;

    assign w_region  = decode_addr(address_dmem, 32'(RAM_WORDS));
    assign w_ram_idx = address_dmem[RAM_AW-1:0];

    assign w_wr_ram   = wren && (w_region == REGION_RAM);
    assign w_wr_cycle = wren && (w_region == REGION_CYCLE);
    assign w_wr_led   = wren && (w_region == REGION_LED);
    assign w_wr_push  = wren && (w_region == REGION_TX_PUSH);
    assign w_wr_stat  = wren && (w_region == REGION_TX_STAT);

    tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .i_clk       (clock),
        .i_rst_n     (reset),
        .i_push      (w_wr_push),
        .i_push_data (data[7:0]),
        .i_pop       (tx_ready),
        .o_head      (tx_data),
        .o_valid     (tx_valid),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count),
        .o_overflow  (w_fifo_ovf)
    );

    always_comb begin
        w_status                 = '0;
        w_status[STAT_COUNT_W-1:0] = STAT_COUNT_W'(w_fifo_count);
        w_status[STAT_EMPTY_BIT] = w_fifo_empty;
        w_status[STAT_FULL_BIT]  = w_fifo_full;
        w_status[STAT_OVF_BIT]   = r_ovf;
    end

    // An overflow in the same cycle as a clear leaves the flag set.
    always_comb begin
        w_ovf_next = r_ovf;
        if (w_wr_stat && data[STAT_OVF_BIT]) begin
            w_ovf_next = 1'b0;
        end
        if (w_fifo_ovf) begin
            w_ovf_next = 1'b1;
        end
    end

    always_comb begin
        w_reg_rdata = '0;
        case (w_region)
            REGION_CYCLE:   w_reg_rdata = r_cycle;
            REGION_LED:     w_reg_rdata = {16'b0, r_leds};
            REGION_TX_STAT: w_reg_rdata = w_status;
            default:        w_reg_rdata = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cycle     <= '0;
            r_leds      <= '0;
            r_ovf       <= 1'b0;
            r_rd_is_ram <= 1'b0;
            r_reg_q     <= '0;
        end else begin
            r_cycle     <= w_wr_cycle ? data : r_cycle + 32'd1;
            if (w_wr_led) begin
                r_leds <= data[15:0];
            end
            r_ovf       <= w_ovf_next;
            r_rd_is_ram <= (w_region == REGION_RAM);
            r_reg_q     <= w_reg_rdata;
        end
    end

    // Read-first block RAM: the read register captures the word before any write lands.
    always_ff @(posedge clock) begin
        if (w_wr_ram) begin
            r_ram[w_ram_idx] <= data;
        end
        r_ram_q <= r_ram[w_ram_idx];
    end

    // r_rd_is_ram is cleared by reset, so q_dmem is forced to zero independent of r_ram_q.
    assign q_dmem = r_rd_is_ram ? r_ram_q : r_reg_q;
    assign leds   = r_leds;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM, unmapped space, registers, TX FIFO and reset.
module tb_dmem_responder;

    localparam logic [31:0] A_CYCLE = 32'h0000_F000;
    localparam logic [31:0] A_LED   = 32'h0000_F001;
    localparam logic [31:0] A_PUSH  = 32'h0000_F002;
    localparam logic [31:0] A_STAT  = 32'h0000_F003;

    logic        clock;
    logic        reset;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic [15:0] leds;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int checks   = 0;
    int failures = 0;

    dmem_responder #(
        .RAM_WORDS  (4096),
        .FIFO_DEPTH (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .leds         (leds),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        address_dmem = a;
        data         = d;
        wren         = 1'b1;
        tick();
        wren         = 1'b0;
        $display("WR addr=%08h data=%08h", a, d);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] v);
        address_dmem = a;
        wren         = 1'b0;
        tick();
        v = q_dmem;
        $display("RD addr=%08h q=%08h", a, v);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b0; wren = 1'b0; tx_ready = 1'b0;
        address_dmem = A_CYCLE; data = '0;
        #12;
        checks++;
        if (q_dmem !== 32'h0) begin failures++; $display("FAIL reset_q got=%08h exp=%08h", q_dmem, 32'h0); end
        checks++;
        if (leds !== 16'h0) begin failures++; $display("FAIL reset_leds got=%04h exp=%04h", leds, 16'h0); end
        checks++;
        if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_txvalid got=%b exp=0", tx_valid); end
        reset = 1'b1;
        do_read(A_CYCLE, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL cycle_first got=%08h exp=%08h", v, 32'h0); end
        do_read(A_CYCLE, v);
        checks++;
        if (v !== 32'h1) begin failures++; $display("FAIL cycle_second got=%08h exp=%08h", v, 32'h1); end
        do_read(A_STAT, v);
        checks++;
        if (v !== 32'h0000_0100) begin failures++; $display("FAIL reset_status got=%08h exp=%08h", v, 32'h100); end
    endtask

    task automatic test_ram();
        logic [31:0] v;
        do_write(32'd0, 32'h1111_1111);
        do_write(32'd5, 32'hDEAD_BEEF);
        do_read(32'd5, v);
        checks++;
        if (v !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_rd5 got=%08h exp=%08h", v, 32'hDEADBEEF); end
        address_dmem = 32'd5; data = 32'h1234_5678; wren = 1'b1;
        tick();
        wren = 1'b0;
        checks++;
        if (q_dmem !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_rw_old got=%08h exp=%08h", q_dmem, 32'hDEADBEEF); end
        do_read(32'd5, v);
        checks++;
        if (v !== 32'h1234_5678) begin failures++; $display("FAIL ram_rd5_new got=%08h exp=%08h", v, 32'h12345678); end
        do_write(32'd4095, 32'hA5A5_A5A5);
        do_read(32'd4095, v);
        checks++;
        if (v !== 32'hA5A5_A5A5) begin failures++; $display("FAIL ram_top got=%08h exp=%08h", v, 32'hA5A5A5A5); end
        do_write(32'd4096, 32'h2222_2222);
        do_read(32'd4096, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL ram_past_end got=%08h exp=%08h", v, 32'h0); end
        do_read(32'd0, v);
        checks++;
        if (v !== 32'h1111_1111) begin failures++; $display("FAIL ram_alias0 got=%08h exp=%08h", v, 32'h11111111); end
    endtask

    task automatic test_unmapped();
        logic [31:0] v;
        do_write(32'h0001_0000, 32'hCAFE_F00D);
        do_read(32'h0001_0000, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL unmapped_rd got=%08h exp=%08h", v, 32'h0); end
        do_read(32'd0, v);
        checks++;
        if (v !== 32'h1111_1111) begin failures++; $display("FAIL unmapped_ram got=%08h exp=%08h", v, 32'h11111111); end
        do_read(A_LED, v);
        checks++;
        if (v !== 32'h0 || leds !== 16'h0) begin failures++; $display("FAIL unmapped_led got=%08h exp=%08h", v, 32'h0); end
        do_read(32'h0000_F004, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL unmapped_f004 got=%08h exp=%08h", v, 32'h0); end
        do_read(A_PUSH, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL push_port_rd got=%08h exp=%08h", v, 32'h0); end
    endtask

    task automatic test_leds();
        logic [31:0] v;
        do_write(A_LED, 32'h1234_ABCD);
        checks++;
        if (leds !== 16'hABCD) begin failures++; $display("FAIL leds_port got=%04h exp=%04h", leds, 16'hABCD); end
        do_read(A_LED, v);
        checks++;
        if (v !== 32'h0000_ABCD) begin failures++; $display("FAIL leds_rd got=%08h exp=%08h", v, 32'hABCD); end
    endtask

    task automatic test_cycle();
        logic [31:0] exp_seq [3];
        exp_seq[0] = 32'hFFFF_FFFF;
        exp_seq[1] = 32'h0000_0000;
        exp_seq[2] = 32'h0000_0001;
        do_write(A_CYCLE, 32'hFFFF_FFFE);
        address_dmem = A_CYCLE;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            $display("RD addr=%08h q=%08h", A_CYCLE, q_dmem);
            checks++;
            if (q_dmem !== exp_seq[i]) begin failures++; $display("FAIL cycle_wrap%0d got=%08h exp=%08h", i, q_dmem, exp_seq[i]); end
        end
    endtask

    task automatic test_tx_fill();
        logic [31:0] v;
        logic [7:0]  exp_b;
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            do_write(A_PUSH, 32'h41 + 32'(i));
            if (i == 0) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin failures++; $display("FAIL first_push got=%b/%02h exp=1/41", tx_valid, tx_data); end
            end
        end
        do_read(A_STAT, v);
        checks++;
        if (v !== 32'h8000_0208) begin failures++; $display("FAIL fill_status got=%08h exp=%08h", v, 32'h80000208); end
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_b = 8'h41 + 8'(i);
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_b) begin failures++; $display("FAIL drain%0d got=%b/%02h exp=1/%02h", i, tx_valid, tx_data, exp_b); end
            $display("TX byte=%02h", tx_data);
            tick();
        end
        tx_ready = 1'b0;
        checks++;
        if (tx_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", tx_valid); end
        do_read(A_STAT, v);
        checks++;
        if (v !== 32'h8000_0100) begin failures++; $display("FAIL drain_status got=%08h exp=%08h", v, 32'h80000100); end
        do_write(A_STAT, 32'h7FFF_FFFF);
        do_read(A_STAT, v);
        checks++;
        if (v !== 32'h8000_0100) begin failures++; $display("FAIL ovf_keep got=%08h exp=%08h", v, 32'h80000100); end
        do_write(A_STAT, 32'h8000_0000);
        do_read(A_STAT, v);
        checks++;
        if (v !== 32'h0000_0100) begin failures++; $display("FAIL ovf_clear got=%08h exp=%08h", v, 32'h100); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] v;
        logic [7:0]  exp_b;
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            do_write(A_PUSH, 32'h61 + 32'(i));
        end
        do_read(A_STAT, v);
        checks++;
        if (v !== 32'h0000_0208) begin failures++; $display("FAIL full_status got=%08h exp=%08h", v, 32'h208); end
        address_dmem = A_PUSH; data = 32'h5A; wren = 1'b1; tx_ready = 1'b1;
        tick();
        wren = 1'b0; tx_ready = 1'b0;
        $display("WR addr=%08h data=%08h with pop", A_PUSH, 32'h5A);
        do_read(A_STAT, v);
        checks++;
        if (v !== 32'h0000_0208) begin failures++; $display("FAIL fullpp_status got=%08h exp=%08h", v, 32'h208); end
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_b = (i < 7) ? 8'h62 + 8'(i) : 8'h5A;
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_b) begin failures++; $display("FAIL fullpp_drain%0d got=%b/%02h exp=1/%02h", i, tx_valid, tx_data, exp_b); end
            $display("TX byte=%02h", tx_data);
            tick();
        end
        tx_ready = 1'b0;
        checks++;
        if (tx_valid !== 1'b0) begin failures++; $display("FAIL fullpp_empty got=%b exp=0", tx_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        do_write(A_PUSH, 32'h30);
        address_dmem = A_PUSH; data = 32'h31; wren = 1'b1; tx_ready = 1'b1;
        tick();
        wren = 1'b0; tx_ready = 1'b0;
        $display("WR addr=%08h data=%08h with pop", A_PUSH, 32'h31);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h31) begin failures++; $display("FAIL b2b_head got=%b/%02h exp=1/31", tx_valid, tx_data); end
        do_read(A_STAT, v);
        checks++;
        if (v !== 32'h0000_0001) begin failures++; $display("FAIL b2b_status got=%08h exp=%08h", v, 32'h1); end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        for (int i = 0; i < 3; i++) begin
            do_write(A_PUSH, 32'h71 + 32'(i));
        end
        do_write(A_LED, 32'h0000_AAAA);
        do_read(A_STAT, v);
        checks++;
        if (v !== 32'h0000_0003 || leds !== 16'hAAAA) begin failures++; $display("FAIL pre_reset got=%08h/%04h exp=00000003/aaaa", v, leds); end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || leds !== 16'h0 || q_dmem !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset got=%b/%04h/%08h exp=0/0000/00000000", tx_valid, leds, q_dmem);
        end
        tick();
        checks++;
        if (tx_valid !== 1'b0 || q_dmem !== 32'h0) begin failures++; $display("FAIL held_reset got=%b/%08h exp=0/00000000", tx_valid, q_dmem); end
        reset = 1'b1;
        do_read(A_STAT, v);
        checks++;
        if (v !== 32'h0000_0100) begin failures++; $display("FAIL post_reset_status got=%08h exp=%08h", v, 32'h100); end
        do_read(A_CYCLE, v);
        checks++;
        if (v !== 32'h1) begin failures++; $display("FAIL post_reset_cycle got=%08h exp=%08h", v, 32'h1); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_unmapped();
        test_leds();
        test_cycle();
        test_tx_fill();
        test_full_push_pop();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
